// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file and trap controller for the EX stage
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_tval_i,
  input  logic [11:0] csr_addr_i,
  input  logic [2:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  input  logic        ex_ecall_i,
  input  logic        ex_ebreak_i,
  input  logic        ex_mret_i,
  input  logic        ex_illegal_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  input  logic        instr_retire_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_RW   = 3'd1;
  localparam logic [2:0] OP_RS   = 3'd2;
  localparam logic [2:0] OP_RC   = 3'd3;
  localparam logic [2:0] OP_RWI  = 3'd5;
  localparam logic [2:0] OP_RSI  = 3'd6;
  localparam logic [2:0] OP_RCI  = 3'd7;

  logic        status_mie_q, status_mie_d;
  logic        status_mpie_q, status_mpie_d;
  logic        mie_meie_q, mie_meie_d;
  logic        mie_mtie_q, mie_mtie_d;
  logic [31:2] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:2] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`else
  logic        unused_retire;
  assign unused_retire = instr_retire_i;
`endif

  logic [31:0] mstatus_val, mie_val, mip_val, irq_pend;
  logic [31:0] rval, wval;
  logic        impl, ro_addr, op_active, wr_attempt, csr_illegal;
  logic        irq_take, illegal_take, trap, mret_take, csr_we;
  logic [31:0] trap_cause, trap_tval;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, status_mpie_q, 3'b0, status_mie_q, 3'b0};
  assign mie_val     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
  assign mip_val     = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 7'b0};

  always_comb begin
    impl = 1'b1;
    rval = 32'h0;
    case (csr_addr_i)
      12'h300: rval = mstatus_val;
      12'h301: rval = MISA_VALUE;
      12'h304: rval = mie_val;
      12'h305: rval = {mtvec_q, 2'b00};
      12'h340: rval = mscratch_q;
      12'h341: rval = {mepc_q, 2'b00};
      12'h342: rval = mcause_q;
      12'h343: rval = mtval_q;
      12'h344: rval = mip_val;
      12'hF14: rval = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: rval = mcycle_q[31:0];
      12'hB80, 12'hC80: rval = mcycle_q[63:32];
      12'hB02, 12'hC02: rval = minstret_q[31:0];
      12'hB82, 12'hC82: rval = minstret_q[63:32];
`endif
      default: impl = 1'b0;
    endcase
  end

  assign op_active   = (csr_op_i != OP_NONE);
  assign csr_rdata_o = op_active ? rval : 32'h0;
  assign ro_addr     = (csr_addr_i[11:10] == 2'b11) || (csr_addr_i == 12'h301) ||
                       (csr_addr_i == 12'h344);

  // Set/clear forms with a zero operand are pure reads and never count as writes.
  always_comb begin
    wr_attempt = 1'b0;
    wval       = rval;
    case (csr_op_i)
      OP_RW, OP_RWI: begin
        wr_attempt = 1'b1;
        wval       = csr_wdata_i;
      end
      OP_RS, OP_RSI: begin
        wr_attempt = (csr_wdata_i != 32'h0);
        wval       = rval | csr_wdata_i;
      end
      OP_RC, OP_RCI: begin
        wr_attempt = (csr_wdata_i != 32'h0);
        wval       = rval & ~csr_wdata_i;
      end
      default: ;
    endcase
  end

  assign csr_illegal  = op_active && (!impl || (wr_attempt && ro_addr));
  assign irq_pend     = mie_val & mip_val;
  assign irq_take     = status_mie_q && (|irq_pend) && ex_valid_i;
  assign illegal_take = ex_illegal_i || csr_illegal;
  assign trap         = illegal_take || ex_ebreak_i || ex_ecall_i || irq_take;
  assign mret_take    = ex_mret_i && !trap;
  assign csr_we       = wr_attempt && !trap;

  always_comb begin
    trap_cause = 32'h0;
    trap_tval  = 32'h0;
    if (illegal_take) begin
      trap_cause = 32'd2;
      trap_tval  = ex_tval_i;
    end else if (ex_ebreak_i) begin
      trap_cause = 32'd3;
      trap_tval  = ex_pc_i;
    end else if (ex_ecall_i) begin
      trap_cause = 32'd11;
    end else if (irq_pend[11]) begin
      trap_cause = 32'h8000_000B;
    end else begin
      trap_cause = 32'h8000_0007;
    end
  end

  assign redirect_o    = trap || mret_take;
  assign redirect_pc_o = trap      ? {mtvec_q, 2'b00} :
                         mret_take ? {mepc_q, 2'b00}  : 32'h0;

  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mie_meie_d    = mie_meie_q;
    mie_mtie_d    = mie_mtie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d      = mcycle_q + 64'd1;
    minstret_d    = minstret_q + {63'b0, instr_retire_i};
`endif
    if (trap) begin
      mepc_d        = ex_pc_i[31:2];
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
      mcause_d      = trap_cause;
      mtval_d       = trap_tval;
    end else if (mret_take) begin
      status_mie_d  = status_mpie_q;
      status_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr_i)
        12'h300: begin
          status_mie_d  = wval[3];
          status_mpie_d = wval[7];
        end
        12'h304: begin
          mie_meie_d = wval[11];
          mie_mtie_d = wval[7];
        end
        12'h305: mtvec_d    = wval[31:2];
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval[31:2];
        12'h342: mcause_d   = wval;
        12'h343: mtval_d    = wval;
`ifdef CSR_COUNTERS_EN
        12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
        12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wval};
        12'hB82: minstret_d = {wval, minstret_q[31:0]};
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_meie_q    <= 1'b0;
      mie_mtie_q    <= 1'b0;
      mtvec_q       <= MTVEC_RESET[31:2];
      mscratch_q    <= 32'h0;
      mepc_q        <= 30'h0;
      mcause_q      <= 32'h0;
      mtval_q       <= 32'h0;
`ifdef CSR_COUNTERS_EN
      mcycle_q      <= 64'h0;
      minstret_q    <= 64'h0;
`endif
    end else begin
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mie_meie_q    <= mie_meie_d;
      mie_mtie_q    <= mie_mtie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - scoreboard bench for csr_file (define CSR_COUNTERS_EN to cover counters)
module tb_csr_file;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_RW   = 3'd1;
  localparam logic [2:0] OP_RS   = 3'd2;
  localparam logic [2:0] OP_RC   = 3'd3;
  localparam logic [2:0] OP_RSI  = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ecall, ex_ebreak, ex_mret, ex_illegal;
  logic        irq_timer, irq_ext, instr_retire;
  logic [31:0] ex_pc, ex_tval, csr_wdata, csr_rdata, redirect_pc;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic        redirect;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rd;
    logic        redir;
    logic [31:0] pc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  bit    mon_en = 1'b0;
  int    n_cmp  = 0;
  int    n_err  = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid),
    .ex_pc_i       (ex_pc),
    .ex_tval_i     (ex_tval),
    .csr_addr_i    (csr_addr),
    .csr_op_i      (csr_op),
    .csr_wdata_i   (csr_wdata),
    .csr_rdata_o   (csr_rdata),
    .ex_ecall_i    (ex_ecall),
    .ex_ebreak_i   (ex_ebreak),
    .ex_mret_i     (ex_mret),
    .ex_illegal_i  (ex_illegal),
    .irq_timer_i   (irq_timer),
    .irq_ext_i     (irq_ext),
    .instr_retire_i(instr_retire),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (e.chk_rd) check({t, "/rdata"}, csr_rdata, e.rdata);
        check({t, "/redirect"}, {31'b0, redirect}, {31'b0, e.redir});
        check({t, "/redirect_pc"}, redirect_pc, e.pc);
      end
    end
  end

  task automatic idle();
    csr_op = OP_NONE; csr_addr = 12'h0; csr_wdata = 32'h0;
    ex_valid = 1'b0; ex_ecall = 1'b0; ex_ebreak = 1'b0; ex_mret = 1'b0; ex_illegal = 1'b0;
    irq_timer = 1'b0; irq_ext = 1'b0; instr_retire = 1'b0;
    mon_en = 1'b0;
  endtask

  // Drives one EX cycle (called #1 after a posedge); event inputs set beforehand are cleared after.
  task automatic step(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eredir, input logic [31:0] epc,
                      input string tag, input bit chk = 1'b1);
    exp_t e;
    csr_op = op; csr_addr = addr; csr_wdata = wd;
    e.rdata = erd; e.chk_rd = chk; e.redir = eredir; e.pc = epc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    step(OP_RS, addr, 32'h0, exp, 1'b0, 32'h0, tag);
  endtask

  initial begin
    idle();
    ex_pc = 32'h0; ex_tval = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    step(OP_NONE, 12'h300, 32'h0, 32'h0, 1'b0, 32'h0, "idle");
    rd(12'h300, 32'h0000_1800, "mstatus_rst");
    rd(12'h305, 32'h0, "mtvec_rst");
    rd(12'h341, 32'h0, "mepc_rst");
    rd(12'h301, 32'h4000_0100, "misa");

    step(OP_RW, 12'h340, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, "mscratch_rw");
    rd(12'h340, 32'hDEAD_BEEF, "mscratch_rs0");
    step(OP_RC, 12'h340, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, "mscratch_rc0");
    rd(12'h340, 32'hDEAD_BEEF, "mscratch_kept");
    step(OP_RC, 12'h340, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0, 32'h0, "mscratch_rc");
    step(OP_RSI, 12'h340, 32'h5, 32'hDEAD_0000, 1'b0, 32'h0, "mscratch_rsi");
    rd(12'h340, 32'hDEAD_0005, "mscratch_set");

    step(OP_RW, 12'h305, 32'h103, 32'h0, 1'b0, 32'h0, "mtvec_w");
    rd(12'h305, 32'h100, "mtvec_mask");
    step(OP_RW, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, "mie_w");
    rd(12'h304, 32'h880, "mie_mask");
    step(OP_RS, 12'h300, 32'h8, 32'h1800, 1'b0, 32'h0, "mstatus_set");
    rd(12'h300, 32'h1808, "mstatus_mie");

    ex_ecall = 1'b1; ex_pc = 32'h80;
    step(OP_NONE, 12'h0, 32'h0, 32'h0, 1'b1, 32'h100, "ecall");
    rd(12'h341, 32'h80, "ecall_mepc");
    rd(12'h342, 32'd11, "ecall_mcause");
    rd(12'h343, 32'h0, "ecall_mtval");
    rd(12'h300, 32'h1880, "ecall_mstatus");

    ex_mret = 1'b1;
    step(OP_NONE, 12'h0, 32'h0, 32'h0, 1'b1, 32'h80, "mret");
    rd(12'h300, 32'h1888, "mret_mstatus");

    irq_timer = 1'b1; irq_ext = 1'b1; ex_valid = 1'b1; ex_pc = 32'h40;
    step(OP_NONE, 12'h0, 32'h0, 32'h0, 1'b1, 32'h100, "irq_both");
    rd(12'h342, 32'h8000_000B, "irq_mcause");
    rd(12'h341, 32'h40, "irq_mepc");
    rd(12'h300, 32'h1880, "irq_mstatus");
    irq_timer = 1'b1;
    rd(12'h344, 32'h80, "mip_timer");

    ex_mret = 1'b1;
    step(OP_NONE, 12'h0, 32'h0, 32'h0, 1'b1, 32'h40, "mret2");
    ex_mret = 1'b1; irq_timer = 1'b1; ex_valid = 1'b1; ex_pc = 32'h44;
    step(OP_NONE, 12'h0, 32'h0, 32'h0, 1'b1, 32'h100, "mret_vs_irq");
    rd(12'h342, 32'h8000_0007, "timer_mcause");
    rd(12'h341, 32'h44, "timer_mepc");
    rd(12'h300, 32'h1880, "timer_mstatus");

    ex_pc = 32'h200; ex_tval = 32'hDEAD_C0DE;
    step(OP_RW, 12'hF14, 32'h5, 32'h0, 1'b1, 32'h100, "mhartid_write");
    rd(12'h342, 32'd2, "ro_mcause");
    rd(12'h343, 32'hDEAD_C0DE, "ro_mtval");
    rd(12'h341, 32'h200, "ro_mepc");
    rd(12'hF14, 32'h0, "mhartid_read");

    ex_ebreak = 1'b1; ex_pc = 32'h300;
    step(OP_RW, 12'h340, 32'h1234, 32'hDEAD_0005, 1'b1, 32'h100, "ebreak_csr");
    rd(12'h340, 32'hDEAD_0005, "ebreak_no_write");
    rd(12'h342, 32'd3, "ebreak_mcause");
    rd(12'h343, 32'h300, "ebreak_mtval");

    ex_tval = 32'h7C00_2073;
    step(OP_RS, 12'h7C0, 32'h0, 32'h0, 1'b1, 32'h100, "unimpl");
    rd(12'h342, 32'd2, "unimpl_mcause");
    rd(12'h343, 32'h7C00_2073, "unimpl_mtval");

`ifdef CSR_COUNTERS_EN
    step(OP_RW, 12'hB80, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, "mcycleh_w", 1'b0);
    step(OP_RW, 12'hB00, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'h0, "mcycle_w", 1'b0);
    rd(12'hB00, 32'hFFFF_FFFE, "mcycle_lo");
    rd(12'hC00, 32'hFFFF_FFFF, "cycle_lo_inc");
    rd(12'hB80, 32'h0, "mcycle_wrap_hi");
    rd(12'hC80, 32'h0, "cycle_wrap_hi");
    step(OP_RW, 12'hB82, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, "minstreth_w");
    step(OP_RW, 12'hB02, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, "minstret_w");
    rd(12'hC02, 32'hFFFF_FFFF, "instret_lo");
    rd(12'hC82, 32'hFFFF_FFFF, "instret_hi");
    instr_retire = 1'b1;
    step(OP_NONE, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0, "retire");
    rd(12'hB02, 32'h0, "minstret_wrap_lo");
    rd(12'hB82, 32'h0, "minstret_wrap_hi");
    step(OP_RW, 12'hC00, 32'h1, 32'h0, 1'b1, 32'h100, "cycle_ro_write", 1'b0);
    rd(12'h342, 32'd2, "cycle_ro_mcause");
`else
    step(OP_RS, 12'hB00, 32'h0, 32'h0, 1'b1, 32'h100, "mcycle_absent");
    rd(12'h342, 32'd2, "absent_mcause");
`endif

    ex_ecall = 1'b1; ex_pc = 32'h444;
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1;
    ex_ecall = 1'b0; ex_pc = 32'h0;
    rst_n = 1'b1;
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h341, 32'h0, "rst_mepc");
    rd(12'h342, 32'h0, "rst_mcause");
    rd(12'h340, 32'h0, "rst_mscratch");
    rd(12'h305, 32'h0, "rst_mtvec");

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
